// File: rtl/key_cmd_pkg.sv
// Shared command and FSM state encodings for the key command scheduler.
package key_cmd_pkg;

  typedef enum logic [1:0] {
    CMD_START = 2'd0,
    CMD_LEFT  = 2'd1,
    CMD_RIGHT = 2'd2
  } cmd_t;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ISSUE    = 2'd1,
    GAP_WAIT = 2'd2
  } state_t;

  localparam int GAP_CNT_W = 8;

endpackage

// File: rtl/key_cmd_scheduler_cmd_fifo.sv
// In-order command queue: up to three prioritised writes and one pop per cycle, one cycle write-to-visible.
// No backpressure: writes beyond the registered free space are dropped (lowest slot kept) and flagged on o_drop.
module cmd_fifo
  import key_cmd_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  input  logic [2:0]                 i_wr_en,
  input  cmd_t [2:0]                 i_wr_cmd,
  input  logic                       i_rd_en,
  output cmd_t                       o_head,
  output logic [$clog2(DEPTH+1)-1:0] o_count,
  output logic                       o_drop
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);

  cmd_t           mem_q [DEPTH];
  cmd_t           mem_d [DEPTH];
  logic [PW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]  count_q, count_d;
  logic           pop;
  int             acc;
  int             idx;
  int             free;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    o_drop   = 1'b0;
    acc      = 0;
    idx      = 0;
    // Space is judged on the registered count only; a pop this cycle frees nothing yet.
    free     = DEPTH - int'(count_q);
    for (int k = 0; k < 3; k++) begin
      if (i_wr_en[k]) begin
        if (acc < free) begin
          idx = int'(wr_ptr_q) + acc;
          if (idx >= DEPTH) idx = idx - DEPTH;
          mem_d[PW'(idx)] = i_wr_cmd[k];
          acc = acc + 1;
        end else begin
          o_drop = 1'b1;
        end
      end
    end
    idx = int'(wr_ptr_q) + acc;
    if (idx >= DEPTH) idx = idx - DEPTH;
    wr_ptr_d = PW'(idx);

    pop = i_rd_en && (count_q != '0);
    if (pop) begin
      rd_ptr_d = (rd_ptr_q == PW'(DEPTH - 1)) ? '0 : rd_ptr_q + PW'(1);
    end
    count_d = CW'(int'(count_q) + acc - (pop ? 1 : 0));
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= CMD_START;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      mem_q    <= mem_d;
    end
  end

  assign o_head  = mem_q[rd_ptr_q];
  assign o_count = count_q;

endmodule

// File: rtl/key_cmd_scheduler.sv
// Queues debounced key events and replays them as spaced one-cycle pulses; event-to-pulse latency 2 cycles.
// LEFT/RIGHT heads wait for i_busy low and stall the queue; overflowing events are dropped into a sticky flag.
module key_cmd_scheduler
  import key_cmd_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int GAP   = 8
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  input  logic                       i_start,
  input  logic                       i_left,
  input  logic                       i_right,
  input  logic                       i_busy,
  output logic                       o_start,
  output logic                       o_left,
  output logic                       o_right,
  output logic [$clog2(DEPTH+1)-1:0] o_count,
  output logic                       o_overflow
);

  state_t                 state_q, state_d;
  logic [GAP_CNT_W-1:0]   gap_q, gap_d;
  logic                   start_q, start_d;
  logic                   left_q, left_d;
  logic                   right_q, right_d;
  logic                   ovf_q, ovf_d;
  cmd_t [2:0]             wr_cmd;
  cmd_t                   head;
  logic                   drop;
  logic                   issuable;

  assign wr_cmd[0] = CMD_START;
  assign wr_cmd[1] = CMD_LEFT;
  assign wr_cmd[2] = CMD_RIGHT;

  cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
    .i_clk    (i_clk),
    .i_rst_n  (i_rst_n),
    .i_wr_en  ({i_right, i_left, i_start}),
    .i_wr_cmd (wr_cmd),
    .i_rd_en  (state_q == ISSUE),
    .o_head   (head),
    .o_count  (o_count),
    .o_drop   (drop)
  );

  // START never waits for the datapath; moves do, and they hold up everything behind them.
  assign issuable = (head == CMD_START) || !i_busy;

  always_comb begin
    state_d = state_q;
    gap_d   = gap_q;
    start_d = 1'b0;
    left_d  = 1'b0;
    right_d = 1'b0;
    ovf_d   = ovf_q | drop;
    case (state_q)
      IDLE: begin
        if ((o_count != '0) && issuable) begin
          state_d = ISSUE;
          case (head)
            CMD_START: start_d = 1'b1;
            CMD_LEFT:  left_d  = 1'b1;
            CMD_RIGHT: right_d = 1'b1;
            default:   ;
          endcase
        end
      end
      ISSUE: begin
        state_d = GAP_WAIT;
        gap_d   = '0;
      end
      GAP_WAIT: begin
        if (gap_q == GAP_CNT_W'(GAP - 1)) begin
          state_d = IDLE;
          gap_d   = '0;
        end else begin
          gap_d = gap_q + GAP_CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        gap_d   = '0;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      gap_q   <= '0;
      start_q <= 1'b0;
      left_q  <= 1'b0;
      right_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      gap_q   <= gap_d;
      start_q <= start_d;
      left_q  <= left_d;
      right_q <= right_d;
      ovf_q   <= ovf_d;
    end
  end

  assign o_start    = start_q;
  assign o_left     = left_q;
  assign o_right    = right_q;
  assign o_overflow = ovf_q;

endmodule

// File: tb/tb_key_cmd_scheduler.sv
// Randomised and directed bench for key_cmd_scheduler against a queue-based reference model.
module tb_key_cmd_scheduler;

  localparam int DEPTH = 4;
  localparam int GAP   = 8;
  localparam int CW    = $clog2(DEPTH + 1);

  logic          clk   = 1'b0;
  logic          rst_n = 1'b0;
  logic          ev_s  = 1'b0;
  logic          ev_l  = 1'b0;
  logic          ev_r  = 1'b0;
  logic          busy  = 1'b0;
  logic          o_start, o_left, o_right, o_overflow;
  logic [CW-1:0] o_count;

  key_cmd_scheduler #(.DEPTH(DEPTH), .GAP(GAP)) dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_start    (ev_s),
    .i_left     (ev_l),
    .i_right    (ev_r),
    .i_busy     (busy),
    .o_start    (o_start),
    .o_left     (o_left),
    .o_right    (o_right),
    .o_count    (o_count),
    .o_overflow (o_overflow)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: accepted commands in issue order (0=start,1=left,2=right).
  int exp_q[$];
  int mcount     = 0;
  bit movf       = 1'b0;
  bit pend_vld   = 1'b0;
  int pend_kind  = 0;
  int last_pulse = -1000;
  bit armed      = 1'b0;
  int max_cnt    = 0;
  int pcyc_q[$];
  int pkind_q[$];

  always @(negedge clk) begin
    automatic logic [2:0] obs = {o_right, o_left, o_start};
    automatic logic [2:0] expv;
    automatic int cnt_now = mcount;
    automatic int free;
    automatic int acc = 0;
    automatic bit next_pend = 1'b0;
    automatic int next_kind = 0;
    if (armed) begin
      expv = pend_vld ? (3'b001 << pend_kind) : 3'b000;
      check("pulse", 32'(obs), 32'(expv));
      check("count", 32'(o_count), cnt_now);
      check("overflow", 32'(o_overflow), 32'(movf));
      if (int'(o_count) > max_cnt) max_cnt = int'(o_count);
      if (obs != 3'b000) begin
        pcyc_q.push_back(cyc);
        pkind_q.push_back(obs[0] ? 0 : (obs[1] ? 1 : 2));
      end
      if (pend_vld) begin
        if (exp_q.size() > 0) void'(exp_q.pop_front());
        last_pulse = cyc;
      end
    end
    if (!rst_n) begin
      exp_q.delete();
      mcount     = 0;
      movf       = 1'b0;
      pend_vld   = 1'b0;
      last_pulse = cyc - GAP;
      armed      = 1'b1;
    end else if (armed) begin
      // Idle at this cycle with an issuable head means a pulse next cycle.
      if ((cyc >= last_pulse + GAP + 1) && (cnt_now > 0) && (exp_q.size() > 0)) begin
        if ((exp_q[0] == 0) || !busy) begin
          next_pend = 1'b1;
          next_kind = exp_q[0];
        end
      end
      free = DEPTH - cnt_now;
      if (ev_s) begin if (acc < free) begin exp_q.push_back(0); acc++; end else movf = 1'b1; end
      if (ev_l) begin if (acc < free) begin exp_q.push_back(1); acc++; end else movf = 1'b1; end
      if (ev_r) begin if (acc < free) begin exp_q.push_back(2); acc++; end else movf = 1'b1; end
      mcount    = cnt_now + acc - (pend_vld ? 1 : 0);
      pend_vld  = next_pend;
      pend_kind = next_kind;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_log();
    pcyc_q.delete();
    pkind_q.delete();
  endtask

  initial begin
    int ev;
    tick(3);
    rst_n = 1'b1;
    check("rst_count", 32'(o_count), 0);
    check("rst_ovf", 32'(o_overflow), 0);
    check("rst_pulses", 32'({o_start, o_left, o_right}), 0);
    tick(4);

    // Single LEFT: pulse two cycles later, exactly once.
    clear_log();
    ev = cyc; ev_l = 1'b1; tick(1); ev_l = 1'b0;
    check("l_count_n1", 32'(o_count), 1);
    tick(20);
    check("l_num", pcyc_q.size(), 1);
    if (pcyc_q.size() == 1) begin
      check("l_cyc", pcyc_q[0], ev + 2);
      check("l_kind", pkind_q[0], 1);
    end

    // All three in one cycle: start, left, right at GAP+2 spacing.
    clear_log();
    ev = cyc; ev_s = 1'b1; ev_l = 1'b1; ev_r = 1'b1; tick(1);
    ev_s = 1'b0; ev_l = 1'b0; ev_r = 1'b0;
    tick(40);
    check("tri_num", pcyc_q.size(), 3);
    if (pcyc_q.size() == 3) begin
      for (int i = 0; i < 3; i++) begin
        check("tri_kind", pkind_q[i], i);
        check("tri_cyc", pcyc_q[i], ev + 2 + i * (GAP + 2));
      end
    end

    // Busy holds a LEFT head and the START behind it.
    clear_log();
    busy = 1'b1;
    ev_l = 1'b1; tick(1); ev_l = 1'b0;
    ev_s = 1'b1; tick(1); ev_s = 1'b0;
    tick(30);
    check("busy_hold", pcyc_q.size(), 0);
    ev = cyc; busy = 1'b0;
    tick(40);
    check("busy_num", pcyc_q.size(), 2);
    if (pcyc_q.size() == 2) begin
      check("busy_first", pkind_q[0], 1);
      check("busy_second", pkind_q[1], 0);
      check("busy_cyc", pcyc_q[0], ev + 1);
      check("busy_gap", pcyc_q[1] - pcyc_q[0], GAP + 2);
    end

    // Fill to three, then three events: only START fits.
    clear_log();
    busy = 1'b1;
    repeat (3) begin ev_l = 1'b1; tick(1); ev_l = 1'b0; end
    ev_s = 1'b1; ev_l = 1'b1; ev_r = 1'b1; tick(1);
    ev_s = 1'b0; ev_l = 1'b0; ev_r = 1'b0;
    check("ovf_count", 32'(o_count), DEPTH);
    check("ovf_flag", 32'(o_overflow), 1);
    busy = 1'b0;
    tick(60);
    check("ovf_num", pcyc_q.size(), 4);
    if (pcyc_q.size() == 4) check("ovf_last", pkind_q[3], 0);
    check("ovf_sticky", 32'(o_overflow), 1);

    // Reset during GAP_WAIT with two entries left.
    ev = cyc; ev_s = 1'b1; ev_l = 1'b1; ev_r = 1'b1; tick(1);
    ev_s = 1'b0; ev_l = 1'b0; ev_r = 1'b0;
    tick(4);
    check("gw_count", 32'(o_count), 2);
    rst_n = 1'b0; ev_l = 1'b1; tick(1); rst_n = 1'b1; ev_l = 1'b0;
    check("rst_gw_count", 32'(o_count), 0);
    check("rst_gw_ovf", 32'(o_overflow), 0);
    clear_log();
    tick(40);
    check("rst_gw_quiet", pcyc_q.size(), 0);

    // 20 alternating moves, one every 10 cycles, random busy.
    for (int i = 0; i < 20; i++) begin
      for (int j = 0; j < 10; j++) begin
        busy = ($urandom_range(3) == 0);
        ev_l = (j == 0) && (i % 2 == 0);
        ev_r = (j == 0) && (i % 2 == 1);
        tick(1);
      end
    end
    ev_l = 1'b0; ev_r = 1'b0;

    // Free-running random traffic.
    for (int i = 0; i < 400; i++) begin
      ev_s = ($urandom_range(7) == 0);
      ev_l = ($urandom_range(5) == 0);
      ev_r = ($urandom_range(5) == 0);
      if ($urandom_range(15) == 0) busy = ~busy;
      tick(1);
    end
    ev_s = 1'b0; ev_l = 1'b0; ev_r = 1'b0; busy = 1'b0;
    tick(80);
    check("drain_empty", exp_q.size(), 0);
    check("drain_count", 32'(o_count), 0);
    check("max_count_ok", 32'(max_cnt <= DEPTH), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/key_cmd_scheduler.md
KEY_CMD_SCHEDULER -- requirements
Module: key_cmd_scheduler

Interface
REQ-001 Parameter DEPTH, default 4, SHALL set the number of command queue entries (legal range 2..16).
REQ-002 Parameter GAP, default 8, SHALL set the minimum idle cycles after each issued pulse (legal range 1..255).
REQ-003 i_clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 i_rst_n  input  1  SHALL be the reset: synchronous, active-low.
REQ-005 i_start  input  1  SHALL be the one-cycle debounced start key event.
REQ-006 i_left  input  1  SHALL be the one-cycle debounced left key event.
REQ-007 i_right  input  1  SHALL be the one-cycle debounced right key event.
REQ-008 i_busy  input  1  SHALL indicate the random generator datapath is running.
REQ-009 o_start  output  1  SHALL be the one-cycle start pulse to the datapath.
REQ-010 o_left  output  1  SHALL be the one-cycle left pulse to the datapath.
REQ-011 o_right  output  1  SHALL be the one-cycle right pulse to the datapath.
REQ-012 o_count  output  $clog2(DEPTH+1)  SHALL give the current queue occupancy.
REQ-013 o_overflow  output  1  SHALL be a sticky flag set when any event is dropped.

Function
REQ-014 Events SHALL enqueue into an in-order FIFO of 2-bit commands (START, LEFT, RIGHT); up to three writes per cycle.
REQ-015 Same-cycle events SHALL enqueue in order START, LEFT, RIGHT.
REQ-016 Free space SHALL be DEPTH minus registered o_count; a same-cycle dequeue SHALL NOT free space for that cycle's writes.
REQ-017 Events exceeding free space SHALL be dropped in reverse priority (RIGHT first, then LEFT, then START) and SHALL set o_overflow.
REQ-018 FSM states SHALL be IDLE, ISSUE, GAP_WAIT.
REQ-019 IDLE -> ISSUE SHALL occur when the queue is non-empty and the head is issuable; otherwise the FSM SHALL remain in IDLE.
REQ-020 A START head SHALL always be issuable; a LEFT/RIGHT head SHALL be issuable only while i_busy is 0.
REQ-021 A blocked LEFT/RIGHT head SHALL block all later entries (no reordering).
REQ-022 In ISSUE, exactly one of o_start/o_left/o_right SHALL be 1 for one cycle, the head SHALL be popped, and the FSM SHALL go to GAP_WAIT.
REQ-023 GAP_WAIT SHALL last exactly GAP cycles, then return to IDLE.
REQ-024 All outputs SHALL be registered; o_start/o_left/o_right SHALL never be high simultaneously.
REQ-025 Event at cycle n into an empty queue with FSM in IDLE SHALL produce its pulse at cycle n+2.
REQ-026 Back-to-back pulse spacing SHALL be GAP+2 cycles minimum (ISSUE, GAP_WAIT x GAP, IDLE).
REQ-027 Pointers SHALL wrap modulo DEPTH; o_count SHALL never exceed DEPTH or underflow.
REQ-028 o_overflow SHALL clear only on reset.

Reset
REQ-029 While i_rst_n is 0 at a clock edge: FSM SHALL go to IDLE, queue SHALL empty, GAP counter SHALL clear, all outputs SHALL be 0.
REQ-030 Reset mid-ISSUE or mid-GAP_WAIT SHALL abort the command with no further pulse.
REQ-031 Events coincident with reset SHALL be discarded.

Structure
REQ-032 Package key_cmd_pkg SHALL hold the cmd_t enum (CMD_START=0, CMD_LEFT=1, CMD_RIGHT=2) and the state_t enum.
REQ-033 The queue SHALL be a sub-module cmd_fifo (multi-write, single-read, count output); FSM and GAP counter SHALL stay in key_cmd_scheduler.

Verification
REQ-034 Single i_left at cycle 10, i_busy=0 -> o_left high only at cycle 12; o_count 1 at cycle 11, 0 at cycle 13.
REQ-035 i_start, i_left, i_right in one cycle, i_busy=0, GAP=8 -> pulses start, left, right exactly 10 cycles apart.
REQ-036 i_busy=1, queue LEFT then START -> no pulse until i_busy falls; then left, then start 10 cycles later.
REQ-037 DEPTH=4, 3 entries queued, all three events in one cycle -> START accepted, LEFT/RIGHT dropped, o_overflow=1, o_count=4.
REQ-038 i_rst_n=0 during GAP_WAIT with 2 entries queued -> next cycle o_count=0, o_overflow=0, no pulses after reset release.
REQ-039 20 alternating LEFT/RIGHT events over 200 cycles with DEPTH=4 -> issue order matches accepted order; pointer wrap exercised; o_count never above 4.
